ddr_local_mem: RTL and testbench
================================

# ddr_local_mem

Single-clock, synthesizable memory model that implements the DDR controller local (Avalon-style burst) interface. It sits in place of the DDR controller IP plus SDRAM model, on the local side of the Wishbone-to-DDR bridge. It lets the bridge and its Wishbone masters be simulated and verified quickly, without PHY, PLL or SDRAM timing. It provides realistic init delay, read latency, burst sequencing, byte enables and periodic refresh stalls.

## Interface
- ADDR_WIDTH, 23: width of local_address (32-bit word address).
- DEPTH_LOG2, 10: storage is 2^DEPTH_LOG2 words; local_address is used modulo depth.
- INIT_CYCLES, 16: cycles after reset before init completes (must be ≥1).
- READ_LATENCY, 4: cycles from read accept to first read beat (must be ≥2).
- REFRESH_INTERVAL, 0: cycles between refresh requests; 0 disables refresh.
- REFRESH_CYCLES, 4: stall length of one refresh.
- wb_clk  in  1  sole clock, rising edge.
- wb_rst  in  1  synchronous, active-high reset.
- local_address  in  ADDR_WIDTH  burst start word address.
- local_write_req  in  1  write beat valid.
- local_read_req  in  1  read burst request.
- local_burstbegin  in  1  marks first beat or request of a burst.
- local_wdata  in  32  write data.
- local_be  in  4  byte enables; bit n covers wdata[8n+7:8n].
- local_size  in  7  burst length in words, 1..64.
- local_ready  out  1  request/beat accepted on this edge when high.
- local_rdata  out  32  read data.
- local_rdata_valid  out  1  read beat valid.
- local_init_done  out  1  initialization complete, sticky until reset.
- local_refresh_ack  out  1  one-cycle pulse at refresh end.

## Operation
- States: INIT, IDLE, WR_BURST, RD_WAIT, RD_DATA, REFRESH.
- Reset values of outputs:
  - local_ready=0, local_rdata_valid=0, local_init_done=0, local_refresh_ack=0.
  - local_rdata=0.
- Memory array is not cleared by reset; its contents are retained across reset.
- INIT: counts INIT_CYCLES, then sets local_init_done and enters IDLE.
- Accept rules: a request or beat is accepted only on an edge where local_ready=1.
- Write start, IDLE:
  - Accept when write_req & burstbegin.
  - Latch address A and size N, then write beat 0 to A.
  - If N>1, enter WR_BURST; otherwise remain in IDLE.
- WR_BURST:
  - Each edge with write_req & ready writes beat k to (A+k) mod depth.
  - Returns to IDLE after beat N-1.
  - local_burstbegin is ignored mid-burst.
- Byte enables: only bytes with local_be set are updated; be=0 leaves the word unchanged but still counts as a beat.
- Read start, IDLE: accept when read_req & burstbegin; latch A and N, enter RD_WAIT.
- Read data:
  - Beat k returns mem[(A+k) mod depth] with local_rdata_valid=1.
  - Beats are consecutive, one per cycle; only one read is outstanding at a time.
- local_ready is 1 only in IDLE and WR_BURST; it is 0 in INIT, RD_WAIT, RD_DATA and REFRESH.
- local_size=0 is treated as 1.
- Simultaneous write_req and read_req in IDLE: the write wins and the read is ignored; the master must re-request it.
- Refresh (REFRESH_INTERVAL>0):
  - A free-running counter sets a pending flag every REFRESH_INTERVAL cycles.
  - The pending refresh is entered only from IDLE; it is deferred during bursts and reads.
  - Stalls for REFRESH_CYCLES cycles, then pulses local_refresh_ack on the last REFRESH cycle.
  - Pending requests do not accumulate beyond one.
- Reset mid-operation aborts any burst or read, drops rdata_valid and returns to INIT.

## Timing
- Reset released at edge R: local_init_done=1 and local_ready=1 from edge R+INIT_CYCLES.
- Write beat accepted at edge E: memory is updated at E, and a read accepted at E+1 returns the new data.
- Read accepted at edge E:
  - local_rdata_valid is high in cycles following edges E+READ_LATENCY … E+READ_LATENCY+N-1.
  - local_ready returns to 1 after edge E+READ_LATENCY+N-1.
- local_rdata holds its last value when valid is low.

## Test plan
- Reset, INIT_CYCLES=16 -> init_done and ready rise exactly 16 cycles after reset release; all outputs are 0 before that.
- Write 0xDEADBEEF to 0x10 (N=1, be=F), then read 0x10 N=1 -> one valid beat of 0xDEADBEEF exactly 4 cycles after accept.
- Burst write N=8 to 0x20 with data 0..7, beat 3 with be=4'b0011 over prior 0xFFFFFFFF; burst read N=8 -> 0,1,2,0xFFFF0003,4..7 on 8 consecutive valid cycles.
- Burst write N=4 at depth-2 -> wraps to words depth-2, depth-1, 0, 1; read back from depth-2 matches.
- REFRESH_INTERVAL=50 with idle bus -> ready low for 4 cycles and a one-cycle refresh_ack pulse, repeating every 50 cycles; a refresh falling due during an N=64 write burst is deferred until the burst completes.
- Assert wb_rst during RD_DATA -> rdata_valid is 0 the next cycle and init repeats; previously written data is still readable afterwards.

Source files
------------

// File: rtl/ddr_local_mem_if.sv
// Local-side burst bus between the Wishbone-to-DDR bridge and the DDR controller
// (or the memory model standing in for it).
interface ddr_local_mem_if #(
  parameter int ADDR_WIDTH = 23
);
  logic [ADDR_WIDTH-1:0] local_address;
  logic                  local_write_req;
  logic                  local_read_req;
  logic                  local_burstbegin;
  logic [31:0]           local_wdata;
  logic [3:0]            local_be;
  logic [6:0]            local_size;
  logic                  local_ready;
  logic [31:0]           local_rdata;
  logic                  local_rdata_valid;
  logic                  local_init_done;
  logic                  local_refresh_ack;

  modport master (
    output local_address, local_write_req, local_read_req, local_burstbegin,
           local_wdata, local_be, local_size,
    input  local_ready, local_rdata, local_rdata_valid, local_init_done,
           local_refresh_ack
  );

  modport slave (
    input  local_address, local_write_req, local_read_req, local_burstbegin,
           local_wdata, local_be, local_size,
    output local_ready, local_rdata, local_rdata_valid, local_init_done,
           local_refresh_ack
  );
endinterface

// File: rtl/ddr_local_mem.sv
// Behavioural-timing stand-in for a DDR controller plus SDRAM on the local burst bus:
// init delay, fixed read latency, wrapping bursts, byte enables and refresh stalls.
module ddr_local_mem #(
  parameter int ADDR_WIDTH       = 23,
  parameter int DEPTH_LOG2       = 10,
  parameter int INIT_CYCLES      = 16,
  parameter int READ_LATENCY     = 4,
  parameter int REFRESH_INTERVAL = 0,
  parameter int REFRESH_CYCLES   = 4
) (
  input  logic           wb_clk,
  input  logic           wb_rst,
  ddr_local_mem_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] addr_t;
  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_WR_BURST, S_RD_WAIT, S_RD_DATA, S_REFRESH
  } state_t;

  state_t      state, state_next;
  logic [15:0] cnt, ref_cnt;
  addr_t       base, burst_addr, wr_addr;
  logic [6:0]  size, beat, req_size;
  logic        pend, tick, go_ref, last_beat;
  logic        wr_first, wr_beat, rd_first, rd_beat, wr_en;
  logic [31:0] rdata;
  logic        rvalid;
  logic [31:0] mem [DEPTH];
  logic        unused_addr_bits;

  // Words beyond the array depth alias onto it.
  assign unused_addr_bits = ^bus.local_address[ADDR_WIDTH-1:DEPTH_LOG2];

  assign req_size   = (bus.local_size == 7'd0) ? 7'd1 : bus.local_size;
  assign last_beat  = (beat == size - 7'd1);
  assign burst_addr = base + addr_t'(beat);
  assign wr_addr    = wr_first ? bus.local_address[DEPTH_LOG2-1:0] : burst_addr;
  assign wr_en      = (wr_first || wr_beat) && !wb_rst;
  assign tick       = (REFRESH_INTERVAL > 0) && (ref_cnt == 16'(REFRESH_INTERVAL - 1));
  assign go_ref     = (state == S_IDLE) && (state_next == S_REFRESH);

  assign bus.local_ready       = (state == S_IDLE) || (state == S_WR_BURST);
  assign bus.local_init_done   = (state != S_INIT);
  assign bus.local_refresh_ack = (state == S_REFRESH) && (cnt == 16'(REFRESH_CYCLES - 1));
  assign bus.local_rdata       = rdata;
  assign bus.local_rdata_valid = rvalid;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) state <= S_INIT;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_next = state;
    wr_first   = 1'b0;
    wr_beat    = 1'b0;
    rd_first   = 1'b0;
    rd_beat    = 1'b0;
    case (state)
      S_INIT:     if (cnt == 16'(INIT_CYCLES)) state_next = S_IDLE;
      S_IDLE: begin
        // A new request takes the edge; a pending refresh waits for a quiet IDLE edge.
        if (bus.local_write_req && bus.local_burstbegin) begin
          wr_first = 1'b1;
          if (req_size > 7'd1) state_next = S_WR_BURST;
        end else if (bus.local_read_req && bus.local_burstbegin && !bus.local_write_req) begin
          rd_first   = 1'b1;
          state_next = S_RD_WAIT;
        end else if (pend || tick) begin
          state_next = S_REFRESH;
        end
      end
      S_WR_BURST: if (bus.local_write_req) begin
        wr_beat = 1'b1;
        if (last_beat) state_next = S_IDLE;
      end
      S_RD_WAIT:  if (cnt == 16'(READ_LATENCY - 2)) state_next = S_RD_DATA;
      S_RD_DATA: begin
        rd_beat = 1'b1;
        if (last_beat) state_next = S_IDLE;
      end
      S_REFRESH:  if (cnt == 16'(REFRESH_CYCLES - 1)) state_next = S_IDLE;
      default:    state_next = S_INIT;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      cnt     <= '0;
      ref_cnt <= '0;
      pend    <= 1'b0;
      base    <= '0;
      size    <= 7'd1;
      beat    <= '0;
      rdata   <= '0;
      rvalid  <= 1'b0;
    end else begin
      // cnt measures time spent in the current state.
      cnt     <= (state_next == state) ? cnt + 16'd1 : '0;
      ref_cnt <= tick ? '0 : ref_cnt + 16'd1;
      pend    <= go_ref ? 1'b0 : (pend | tick);
      rvalid  <= rd_beat;
      if (rd_beat) rdata <= mem[burst_addr];
      if (wr_first || rd_first) begin
        base <= bus.local_address[DEPTH_LOG2-1:0];
        size <= req_size;
        beat <= wr_first ? 7'd1 : 7'd0;
      end else if (wr_beat || rd_beat) begin
        beat <= beat + 7'd1;
      end
    end
  end

  // NOTE: the array has no reset so its contents survive wb_rst, as real SDRAM would.
  always_ff @(posedge wb_clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.local_be[i]) mem[wr_addr][8*i +: 8] <= bus.local_wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_ddr_local_mem.sv
// Directed bench for ddr_local_mem: init, single/burst/wrapping transfers, byte enables,
// write-over-read priority, refresh stalls and deferral, and reset during a read.
module tb_ddr_local_mem;
  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst_r = 1'b1;
  int   tests = 0;
  int   fails = 0;

  logic [31:0] wd  [64];
  logic [3:0]  wbe [64];
  logic [31:0] rd  [64];
  logic [31:0] exp8 [8] = '{32'd0, 32'd1, 32'd2, 32'hFFFF0003,
                            32'd4, 32'd5, 32'd6, 32'd7};
  int   bad, n_ack, err_rdy, err_ack;
  logic exp_rdy, exp_ack;

  ddr_local_mem_if #(.ADDR_WIDTH(23)) bus ();
  ddr_local_mem_if #(.ADDR_WIDTH(23)) bus_r ();

  ddr_local_mem #(
    .ADDR_WIDTH(23), .DEPTH_LOG2(10), .INIT_CYCLES(16), .READ_LATENCY(4),
    .REFRESH_INTERVAL(0), .REFRESH_CYCLES(4)
  ) u_dut (.wb_clk(clk), .wb_rst(rst), .bus(bus));

  ddr_local_mem #(
    .ADDR_WIDTH(23), .DEPTH_LOG2(10), .INIT_CYCLES(16), .READ_LATENCY(4),
    .REFRESH_INTERVAL(50), .REFRESH_CYCLES(4)
  ) u_ref (.wb_clk(clk), .wb_rst(rst_r), .bus(bus_r));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int i = 0;
    while (bus.local_ready !== 1'b1 && i < 100) begin
      @(negedge clk);
      i++;
    end
    check(tag, {31'd0, bus.local_ready}, 32'd1);
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic wr_burst(input logic [22:0] a, input int n);
    int beats = (n == 0) ? 1 : n;
    wait_ready("wr_ready");
    for (int k = 0; k < beats; k++) begin
      bus.local_write_req  = 1'b1;
      bus.local_burstbegin = (k == 0);
      bus.local_address    = a;
      bus.local_size       = 7'(n);
      bus.local_wdata      = wd[k];
      bus.local_be         = wbe[k];
      @(negedge clk);
    end
    bus.local_write_req  = 1'b0;
    bus.local_burstbegin = 1'b0;
  endtask

  task automatic rd_burst(input logic [22:0] a, input int n, input string tag);
    int beats = (n == 0) ? 1 : n;
    int lat   = 0;
    int errs  = 0;
    wait_ready({tag, "_ready"});
    bus.local_read_req   = 1'b1;
    bus.local_burstbegin = 1'b1;
    bus.local_address    = a;
    bus.local_size       = 7'(n);
    @(negedge clk);
    bus.local_read_req   = 1'b0;
    bus.local_burstbegin = 1'b0;
    while (bus.local_rdata_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    for (int k = 0; k < beats; k++) begin
      if (bus.local_rdata_valid !== 1'b1 || bus.local_ready !== (k == beats - 1)) errs++;
      rd[k] = bus.local_rdata;
      @(negedge clk);
    end
    check({tag, "_beats"}, 32'(errs), 32'd0);
    check({tag, "_valid_drop"}, {31'd0, bus.local_rdata_valid}, 32'd0);
  endtask

  initial begin
    // NOTE: stimulus uses blocking assignments on the falling edge, clear of the DUT's sampling edge.
    {bus.local_write_req, bus.local_read_req, bus.local_burstbegin} = '0;
    {bus_r.local_write_req, bus_r.local_read_req, bus_r.local_burstbegin} = '0;
    bus.local_address = '0; bus.local_wdata = '0; bus.local_be = '0; bus.local_size = '0;
    bus_r.local_address = '0; bus_r.local_wdata = '0; bus_r.local_be = '0; bus_r.local_size = '0;

    repeat (3) @(negedge clk);
    check("rst_ready",     {31'd0, bus.local_ready},       32'd0);
    check("rst_valid",     {31'd0, bus.local_rdata_valid}, 32'd0);
    check("rst_init_done", {31'd0, bus.local_init_done},   32'd0);
    check("rst_ref_ack",   {31'd0, bus.local_refresh_ack}, 32'd0);
    check("rst_rdata",     bus.local_rdata,                32'd0);

    rst = 1'b0;
    bad = 0;
    repeat (16) begin
      @(negedge clk);
      if (bus.local_init_done !== 1'b0 || bus.local_ready !== 1'b0) bad++;
    end
    check("init_early", 32'(bad), 32'd0);
    @(negedge clk);
    check("init_done",  {31'd0, bus.local_init_done}, 32'd1);
    check("init_ready", {31'd0, bus.local_ready},     32'd1);

    wd[0] = 32'hDEADBEEF; wbe[0] = 4'hF;
    wr_burst(23'h10, 1);
    rd_burst(23'h10, 1, "single");
    check("single_data", rd[0], 32'hDEADBEEF);
    rd_burst(23'h410, 1, "alias");
    check("alias_data", rd[0], 32'hDEADBEEF);

    wd[0] = 32'hFFFFFFFF;
    wr_burst(23'h23, 1);
    for (int k = 0; k < 8; k++) begin
      wd[k]  = 32'(k);
      wbe[k] = (k == 3) ? 4'b0011 : 4'hF;
    end
    wr_burst(23'h20, 8);
    rd_burst(23'h20, 8, "burst8");
    for (int k = 0; k < 8; k++) check($sformatf("burst8_d%0d", k), rd[k], exp8[k]);

    for (int k = 0; k < 4; k++) begin
      wd[k]  = 32'hA5A50000 + 32'(k);
      wbe[k] = 4'hF;
    end
    wr_burst(23'd1022, 4);
    rd_burst(23'd1022, 4, "wrap");
    for (int k = 0; k < 4; k++) check($sformatf("wrap_d%0d", k), rd[k], 32'hA5A50000 + 32'(k));
    rd_burst(23'd0, 2, "wrap0");
    check("wrap0_d0", rd[0], 32'hA5A50002);
    check("wrap0_d1", rd[1], 32'hA5A50003);

    wd[0] = 32'h00005555;
    wr_burst(23'h30, 0);
    check("size0_ready", {31'd0, bus.local_ready}, 32'd1);
    rd_burst(23'h30, 0, "size0");
    check("size0_data", rd[0], 32'h00005555);

    // Write and read requested together: write wins, read is dropped.
    bus.local_write_req = 1'b1; bus.local_read_req = 1'b1; bus.local_burstbegin = 1'b1;
    bus.local_address = 23'h40; bus.local_size = 7'd1;
    bus.local_wdata = 32'h12345678; bus.local_be = 4'hF;
    @(negedge clk);
    {bus.local_write_req, bus.local_read_req, bus.local_burstbegin} = '0;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.local_rdata_valid !== 1'b0) bad++;
    end
    check("wwins_no_read", 32'(bad), 32'd0);
    rd_burst(23'h40, 1, "wwins");
    check("wwins_data", rd[0], 32'h12345678);

    // Reset while read data is streaming.
    wait_ready("rstrd_ready");
    bus.local_read_req = 1'b1; bus.local_burstbegin = 1'b1;
    bus.local_address = 23'h20; bus.local_size = 7'd8;
    @(negedge clk);
    bus.local_read_req = 1'b0; bus.local_burstbegin = 1'b0;
    bad = 0;
    while (bus.local_rdata_valid !== 1'b1 && bad < 20) begin
      @(negedge clk);
      bad++;
    end
    check("rstrd_streaming", {31'd0, bus.local_rdata_valid}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstrd_valid",     {31'd0, bus.local_rdata_valid}, 32'd0);
    check("rstrd_init_done", {31'd0, bus.local_init_done},   32'd0);
    rst = 1'b0;
    bad = 0;
    while (bus.local_init_done !== 1'b1 && bad < 40) begin
      @(negedge clk);
      bad++;
    end
    check("rstrd_reinit", {31'd0, bus.local_init_done}, 32'd1);
    rd_burst(23'h10, 1, "retain");
    check("retain_d0", rd[0], 32'hDEADBEEF);
    rd_burst(23'h23, 1, "retain_be");
    check("retain_d1", rd[0], 32'hFFFF0003);

    // Refresh every 50 cycles on an idle bus: observation n follows edge R+n-1.
    rst_r = 1'b1;
    repeat (2) @(negedge clk);
    rst_r = 1'b0;
    err_rdy = 0; err_ack = 0; n_ack = 0;
    for (int n = 1; n <= 160; n++) begin
      @(negedge clk);
      exp_rdy = (n >= 17) && !((n >= 50 && n <= 53) || (n >= 100 && n <= 103) ||
                               (n >= 150 && n <= 153));
      exp_ack = (n == 53) || (n == 103) || (n == 153);
      if (bus_r.local_ready !== exp_rdy) err_rdy++;
      if (bus_r.local_refresh_ack !== exp_ack) err_ack++;
      if (bus_r.local_refresh_ack === 1'b1) n_ack++;
    end
    check("ref_ready_pattern", 32'(err_rdy), 32'd0);
    check("ref_ack_pattern",   32'(err_ack), 32'd0);
    check("ref_ack_count",     32'(n_ack),   32'd3);

    // A 64-beat burst spans the refresh due at edge R+199; it must wait for the burst.
    repeat (19) @(negedge clk);
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      if (bus_r.local_ready !== 1'b1 || bus_r.local_refresh_ack !== 1'b0) bad++;
      bus_r.local_write_req  = 1'b1;
      bus_r.local_burstbegin = (k == 0);
      bus_r.local_address    = 23'h100;
      bus_r.local_size       = 7'd64;
      bus_r.local_wdata      = 32'(k);
      bus_r.local_be         = 4'hF;
      @(negedge clk);
    end
    bus_r.local_write_req = 1'b0; bus_r.local_burstbegin = 1'b0;
    check("defer_no_stall", 32'(bad), 32'd0);
    check("defer_idle", {31'd0, bus_r.local_ready}, 32'd1);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus_r.local_ready !== 1'b0 || bus_r.local_refresh_ack !== (k == 3)) bad++;
    end
    check("defer_refresh", 32'(bad), 32'd0);
    @(negedge clk);
    check("defer_back", {31'd0, bus_r.local_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
